icache: RTL
===========

Name: icache

Overview:
Direct-mapped, read-only instruction cache that sits directly upstream of the Fetcher.
- Accepts the Fetcher's fetch request (start_fetch/pc) and returns one 32-bit instruction with a one-cycle ready pulse.
- On a miss, refills a whole line word-by-word through the memory controller's instruction port.
- Respects rob_clear flushes and the global rdy stall.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines)
LINE_WORDS_BITS, 2, log2 of 32-bit words per line (4 words = 16 B)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
rob_clear  in  1  pipeline flush from RoB
start_fetch  in  1  fetch request from Fetcher
pc  in  32  fetch address, word aligned
instr_ready  out  1  one-cycle pulse: instr valid
instr  out  32  fetched instruction
instr_addr  out  32  address of instr (pc at request)
mem_req  out  1  word read request to memory controller
mem_addr  out  32  word-aligned refill address
mem_ready  in  1  one-cycle pulse: mem_data valid
mem_data  in  32  returned word

Behaviour:
- Address split: offset [1:0] ignored; word = [LINE_WORDS_BITS+1:2]; index = next INDEX_BITS; tag = remainder. Tag store, valid bits and data array are indexed by index.
- Reset (posedge clk with rst=1): all valid bits 0; state IDLE; instr_ready=0, instr=0, instr_addr=0, mem_req=0, mem_addr=0; refill counter 0; suppress flag 0. rst has priority over rdy.
- rdy=0: no state, output, or array changes. Pulses are held, not consumed, so a stalled instr_ready stays high until the next rdy=1 edge.
- Every rdy=1 edge clears instr_ready unless it is set again on that edge.
- IDLE:
  - A request is start_fetch=1, rob_clear=0 and suppress=0.
  - Hit (valid && tag match): next edge sets instr_ready=1, instr=word, instr_addr=pc, suppress=1. Hit latency is 1 cycle.
  - Miss: latch the line base address and go to REFILL. Counter=0, mem_req=1, mem_addr=base.
- suppress is cleared on the edge after it is set. The cache ignores start_fetch in the cycle the pulse is visible, because the Fetcher lowers start_fetch one edge later. This prevents a duplicate response.
- REFILL, on mem_ready=1:
  - Write mem_data into data[index][counter] and increment the counter.
  - mem_addr advances by 4. mem_req stays high and mem_addr stays stable between pulses.
  - After the last word (counter == 2^LINE_WORDS_BITS-1): set valid and tag, drop mem_req, go to IDLE.
  - The request is then re-looked-up as a hit. Miss latency = memory time + 1.
- rob_clear=1 in IDLE: cancels any response being generated this edge (instr_ready<=0) and clears suppress.
- rob_clear=1 in REFILL: the refill runs to completion, because the memory controller cannot abort. The line is still installed. A flag discards the response: on return to IDLE the cache serves whatever start_fetch/pc present, which is the new back_pc.
- A request changing pc while in REFILL is a protocol error from the Fetcher, except after rob_clear. The cache always re-looks-up the current pc on return to IDLE.
- rob_clear and mem_ready on the same edge: the word is still written and the counter advances.
- No self-modifying-code coherence. Any store to code space requires a cache reset.

Decomposition:
- Shared config.v defines:
  - ICACHE_INDEX_BITS, ICACHE_LINE_WORDS_BITS
  - state encodings ICACHE_IDLE=1'b0, ICACHE_REFILL=1'b1
  - a tag-width macro derived from the two bit counts
- One sub-module, icache_data_ram: data array with one write port (index, word, data, we) and an asynchronous read port (index, word). Tag/valid arrays stay in icache.

Test Plan:
- Reset, then hold start_fetch=0 for 5 cycles -> instr_ready, mem_req and all outputs stay 0.
- Cold miss at pc=0x0, memory returns words 0x00000013, 0x00100093, 0x00200113, 0x00300193 at 3-cycle latency each:
  - mem_addr steps 0x0, 0x4, 0x8, 0xC.
  - mem_req drops after the 4th pulse.
  - Next cycle instr_ready=1 for exactly one cycle with instr=0x00000013, instr_addr=0x0.
- After the above, request pc=0x8 -> instr_ready pulses 1 cycle later with instr=0x00200113, mem_req stays 0. start_fetch held 1 through the pulse cycle -> exactly one pulse.
- Conflict: fetch 0x0 (cached), then 0x400 (same index, different tag) -> refill from 0x400. A later fetch of 0x0 misses again.
- rob_clear during refill of 0x40 with back_pc=0x0 (cached):
  - Refill completes and no pulse is issued for 0x40.
  - Then one pulse is issued with instr_addr=0x0.
  - A later fetch of 0x40 hits.
- rdy=0 for 3 cycles while instr_ready=1 and mid-refill -> instr_ready, mem_req, mem_addr and counter all hold; operation resumes unchanged when rdy=1.

Source files
------------

// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared geometry, state encoding and helpers for the icache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int ICACHE_INDEX_BITS      = 6;
  localparam int ICACHE_LINE_WORDS_BITS = 2;

  // Tag is whatever remains of a 32-bit byte address above index and word.
  function automatic int icache_tag_bits(input int index_bits, input int words_bits);
    return 32 - index_bits - words_bits - 2;
  endfunction

  localparam int ICACHE_TAG_BITS = icache_tag_bits(ICACHE_INDEX_BITS, ICACHE_LINE_WORDS_BITS);

  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_data_ram.sv
// ============================================================================
// Module   : icache_data_ram
// Brief    : Line data array, one synchronous write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_data_ram
  import icache_pkg::*;
#(
  parameter int INDEX_BITS      = ICACHE_INDEX_BITS,
  parameter int LINE_WORDS_BITS = ICACHE_LINE_WORDS_BITS
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [INDEX_BITS-1:0]      i_widx,
  input  logic [LINE_WORDS_BITS-1:0] i_wword,
  input  logic [31:0]                i_wdata,
  input  logic [INDEX_BITS-1:0]      i_ridx,
  input  logic [LINE_WORDS_BITS-1:0] i_rword,
  output logic [31:0]                o_rdata
);

  localparam int DEPTH = 1 << (INDEX_BITS + LINE_WORDS_BITS);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_widx, i_wword}] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[{i_ridx, i_rword}];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped read-only instruction cache with word-wise refill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS      = ICACHE_INDEX_BITS,
  parameter int LINE_WORDS_BITS = ICACHE_LINE_WORDS_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        start_fetch,
  input  logic [31:0] pc,
  output logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int TAG_BITS  = icache_tag_bits(INDEX_BITS, LINE_WORDS_BITS);
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int IDX_LO    = LINE_WORDS_BITS + 2;
  localparam int TAG_LO    = IDX_LO + INDEX_BITS;
  localparam int LINE_BITS = TAG_BITS + INDEX_BITS;

  icache_state_e              r_state, w_state_nxt;
  logic [LINES-1:0]           r_valid;
  logic [TAG_BITS-1:0]        r_tag [LINES];
  logic [LINE_WORDS_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                       r_suppress, w_suppress_nxt;
  logic [LINE_BITS-1:0]       r_line, w_line_nxt;
  logic                       r_instr_ready, w_instr_ready_nxt;
  logic [31:0]                r_instr, w_instr_nxt;
  logic [31:0]                r_instr_addr, w_instr_addr_nxt;
  logic                       r_mem_req, w_mem_req_nxt;
  logic [31:0]                r_mem_addr, w_mem_addr_nxt;
  logic                       w_install;
  logic                       w_ram_we;
  logic [31:0]                w_rdata;

  wire [INDEX_BITS-1:0]      w_idx       = pc[TAG_LO-1:IDX_LO];
  wire [TAG_BITS-1:0]        w_tag       = pc[31:TAG_LO];
  wire [LINE_WORDS_BITS-1:0] w_word      = pc[IDX_LO-1:2];
  wire [INDEX_BITS-1:0]      w_line_idx  = r_line[INDEX_BITS-1:0];
  wire [TAG_BITS-1:0]        w_line_tag  = r_line[LINE_BITS-1:INDEX_BITS];
  wire                       w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  wire                       w_unused_ok = &{1'b0, pc[1:0]};

  icache_data_ram #(
    .INDEX_BITS      (INDEX_BITS),
    .LINE_WORDS_BITS (LINE_WORDS_BITS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we && rdy && !rst),
    .i_widx  (w_line_idx),
    .i_wword (r_cnt),
    .i_wdata (mem_data),
    .i_ridx  (w_idx),
    .i_rword (w_word),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_suppress_nxt    = r_suppress;
    w_line_nxt        = r_line;
    w_instr_ready_nxt = 1'b0;
    w_instr_nxt       = r_instr;
    w_instr_addr_nxt  = r_instr_addr;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_install         = 1'b0;
    w_ram_we          = 1'b0;
    case (r_state)
      ICACHE_IDLE: begin
        // The suppress window lasts exactly one edge; a flush clears it too.
        w_suppress_nxt = 1'b0;
        if (start_fetch && !rob_clear && !r_suppress) begin
          if (w_hit) begin
            w_instr_ready_nxt = 1'b1;
            w_instr_nxt       = w_rdata;
            w_instr_addr_nxt  = pc;
            w_suppress_nxt    = 1'b1;
          end else begin
            w_state_nxt    = ICACHE_REFILL;
            w_cnt_nxt      = '0;
            w_line_nxt     = pc[31:IDX_LO];
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {pc[31:IDX_LO], {IDX_LO{1'b0}}};
          end
        end
      end
      ICACHE_REFILL: begin
        // A flush here cannot abort memory; the line still installs and the
        // current pc is looked up afresh once back in IDLE.
        if (mem_ready) begin
          w_ram_we       = 1'b1;
          w_cnt_nxt      = r_cnt + 1'b1;
          w_mem_addr_nxt = r_mem_addr + 32'd4;
          if (r_cnt == '1) begin
            w_install     = 1'b1;
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = ICACHE_IDLE;
          end
        end
      end
      default: w_state_nxt = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ICACHE_IDLE;
      r_valid       <= '0;
      r_cnt         <= '0;
      r_suppress    <= 1'b0;
      r_line        <= '0;
      r_instr_ready <= 1'b0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_suppress    <= w_suppress_nxt;
      r_line        <= w_line_nxt;
      r_instr_ready <= w_instr_ready_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_addr  <= w_instr_addr_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      if (w_install) begin
        r_valid[w_line_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && w_install) begin
      r_tag[w_line_idx] <= w_line_tag;
    end
  end

  assign instr_ready = r_instr_ready;
  assign instr       = r_instr;
  assign instr_addr  = r_instr_addr;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

endmodule

`default_nettype wire
